// File: rtl/fma16_vector_recorder_if.sv
// Capture-side and vector-memory write-side bundles for the fma16 vector recorder.
interface fma16_cap_if;
   logic        cap_valid;
   logic        cap_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic [15:0] z;
   logic [1:0]  roundmode;
   logic        mul;
   logic        add;
   logic        negp;
   logic        negz;
   logic [15:0] result;
   logic [3:0]  flags;

   modport master (
      output cap_valid, x, y, z, roundmode, mul, add, negp, negz, result, flags,
      input  cap_ready
   );
   modport slave (
      input  cap_valid, x, y, z, roundmode, mul, add, negp, negz, result, flags,
      output cap_ready
   );
endinterface

interface fma16_wr_if #(
   parameter int ADDR_W = 14
);
   logic              wr_en;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [75:0]       wr_data;

   modport master (output wr_en, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/fma16_vector_recorder.sv
// Packs live fma16 operations into 76-bit vector records and streams them through a small FIFO
// to a memory write port; one cycle capture-to-write, capture stalls only on FIFO or memory full.
module fma16_vector_recorder #(
   parameter int FIFO_DEPTH = 4,
   parameter int MEM_DEPTH  = 10001,
   parameter int ADDR_W     = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   fma16_cap_if.slave        cap,
   fma16_wr_if.master        wr,
   output logic [ADDR_W-1:0] rec_count,
   output logic              done,
   output logic              dropped
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]       OCC_FULL  = (PW+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, RECORD, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [7:0]  ctrl;
      logic [15:0] result;
      logic [3:0]  flags;
   } rec_t;

   state_t            state;
   state_t            state_nxt;
   rec_t              fifo_mem [FIFO_DEPTH];
   rec_t              cap_rec;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [PW:0]       occ;
   logic [ADDR_W-1:0] accepted;
   logic [ADDR_W-1:0] wr_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              run_start;
   logic              cap_rdy;
   logic              drain_en;
   logic              wr_vld;
   logic              push;
   logic              pop;

   assign cap_rec = {cap.x, cap.y, cap.z, 2'b00, cap.roundmode, cap.mul, cap.add,
                     cap.negp, cap.negz, cap.result, cap.flags};

   assign fifo_full  = (occ == OCC_FULL);
   assign fifo_empty = (occ == '0);

   always_comb begin
      state_nxt = state;
      run_start = 1'b0;
      cap_rdy   = 1'b0;
      drain_en  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RECORD;
               run_start = 1'b1;
            end
         end
         RECORD: begin
            // Deliberately independent of wr_ready so no combinational path crosses the recorder.
            cap_rdy  = !fifo_full && (accepted < MEM_LIMIT);
            drain_en = 1'b1;
            if (finish) state_nxt = DRAIN;
         end
         DRAIN: begin
            drain_en = 1'b1;
            if (fifo_empty) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_vld = drain_en && !fifo_empty;
   assign push   = cap.cap_valid && cap_rdy;
   assign pop    = wr_vld && wr.wr_ready;

   assign cap.cap_ready = cap_rdy;
   assign wr.wr_en      = wr_vld;
   assign wr.wr_addr    = wr_cnt;
   assign wr.wr_data    = wr_vld ? fifo_mem[rd_ptr] : '0;
   assign rec_count     = wr_cnt;
   assign done          = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         accepted <= '0;
         wr_cnt   <= '0;
         dropped  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (run_start) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            accepted <= '0;
            wr_cnt   <= '0;
            dropped  <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr   <= wr_ptr + PW'(1);
               accepted <= accepted + ADDR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
               wr_cnt <= wr_cnt + ADDR_W'(1);
            end
            case ({push, pop})
               2'b10:   occ <= occ + (PW+1)'(1);
               2'b01:   occ <= occ - (PW+1)'(1);
               default: occ <= occ;
            endcase
            if ((state == RECORD) && cap.cap_valid && (accepted == MEM_LIMIT)) dropped <= 1'b1;
         end
      end
   end

   // Record storage carries no reset; wr_data is gated by wr_en so stale entries never leak out.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cap_rec;
   end
endmodule

// File: tb/tb_fma16_vector_recorder.sv
// Randomized scoreboard bench for fma16_vector_recorder with a queue-based reference model.
module tb_fma16_vector_recorder;
   localparam int MEMD = 12;
   localparam int FD   = 4;

   typedef enum {PH_IDLE, PH_REC, PH_DRAIN, PH_DONE} phase_t;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        start  = 1'b0;
   logic        finish = 1'b0;
   logic [13:0] rec_count;
   logic        done;
   logic        dropped;

   fma16_cap_if               cap_bus ();
   fma16_wr_if #(.ADDR_W(14)) wr_bus ();

   fma16_vector_recorder #(.FIFO_DEPTH(FD), .MEM_DEPTH(MEMD), .ADDR_W(14)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .finish    (finish),
      .cap       (cap_bus),
      .wr        (wr_bus),
      .rec_count (rec_count),
      .done      (done),
      .dropped   (dropped)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [75:0] exp_q [$];
   int          acc_cnt  = 0;
   int          wr_cnt   = 0;
   bit          m_drop   = 1'b0;
   bit          model_on = 1'b0;
   bit          rand_rdy = 1'b0;
   bit          m_rdy;
   bit          m_en;
   phase_t      ph  = PH_IDLE;
   phase_t      nph = PH_IDLE;

   task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Presents one operation and holds it until accepted or max_wait cycles pass.
   task automatic offer(input logic [15:0] ox, input logic [15:0] oy, input logic [15:0] oz,
                        input logic [1:0] rm, input logic [3:0] ctl, input logic [15:0] res,
                        input logic [3:0] fl, input int max_wait, output bit acc);
      logic [75:0] rec;
      int          c;
      c   = rm * 16 + ctl;
      rec = {ox, oy, oz, c[7:0], res, fl};
      cap_bus.x         = ox;
      cap_bus.y         = oy;
      cap_bus.z         = oz;
      cap_bus.roundmode = rm;
      cap_bus.mul       = ctl[3];
      cap_bus.add       = ctl[2];
      cap_bus.negp      = ctl[1];
      cap_bus.negz      = ctl[0];
      cap_bus.result    = res;
      cap_bus.flags     = fl;
      cap_bus.cap_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < max_wait && !acc; i++) begin
         @(negedge clk);
         acc = cap_bus.cap_ready;
         @(posedge clk);
         #1;
      end
      cap_bus.cap_valid = 1'b0;
      if (acc) begin
         exp_q.push_back(rec);
         acc_cnt++;
      end
   endtask

   task automatic rnd_offer(input int max_wait, output bit acc);
      offer(16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 4'($urandom),
            16'($urandom), 4'($urandom), max_wait, acc);
   endtask

   task automatic wait_done(input int max_cyc);
      int i;
      i = 0;
      while (!done && i < max_cyc) begin
         tick(1);
         i++;
      end
      chk("done_reached", 76'(done), 76'(1));
   endtask

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1 wr_bus.wr_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compares every output against the model, then advances the model for the coming edge.
   always @(negedge clk) begin
      if (model_on) begin
         m_rdy = (ph == PH_REC) && (exp_q.size() < FD) && (acc_cnt < MEMD);
         m_en  = ((ph == PH_REC) || (ph == PH_DRAIN)) && (exp_q.size() > 0);
         chk("cap_ready", 76'(cap_bus.cap_ready), 76'(m_rdy));
         chk("wr_en", 76'(wr_bus.wr_en), 76'(m_en));
         chk("wr_addr", 76'(wr_bus.wr_addr), 76'(wr_cnt));
         chk("rec_count", 76'(rec_count), 76'(wr_cnt));
         if (m_en) chk("wr_data", wr_bus.wr_data, exp_q[0]);
         chk("done", 76'(done), 76'(ph == PH_DONE));
         chk("dropped", 76'(dropped), 76'(m_drop));
         if (reset) begin
            ph = PH_IDLE;
            exp_q.delete();
            acc_cnt = 0;
            wr_cnt  = 0;
            m_drop  = 1'b0;
         end else begin
            nph = ph;
            case (ph)
               PH_IDLE, PH_DONE: begin
                  if (start) begin
                     nph = PH_REC;
                     exp_q.delete();
                     acc_cnt = 0;
                     wr_cnt  = 0;
                     m_drop  = 1'b0;
                  end
               end
               PH_REC: begin
                  if (finish) nph = PH_DRAIN;
                  if (cap_bus.cap_valid && acc_cnt >= MEMD) m_drop = 1'b1;
               end
               default: if (exp_q.size() == 0) nph = PH_DONE;
            endcase
            if (m_en && wr_bus.wr_ready) begin
               void'(exp_q.pop_front());
               wr_cnt++;
            end
            ph = nph;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got no end of test, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit a;
      int n_acc;
      cap_bus.cap_valid = 1'b0;
      cap_bus.x = '0; cap_bus.y = '0; cap_bus.z = '0; cap_bus.roundmode = '0;
      cap_bus.mul = 1'b0; cap_bus.add = 1'b0; cap_bus.negp = 1'b0; cap_bus.negz = 1'b0;
      cap_bus.result = '0; cap_bus.flags = '0;
      wr_bus.wr_ready = 1'b0;

      // Reset state
      tick(2);
      model_on = 1'b1;
      tick(2);
      reset = 1'b0;
      chk("reset_wr_data", wr_bus.wr_data, 76'h0);
      chk("reset_cap_ready", 76'(cap_bus.cap_ready), 76'(0));

      // Single capture and control packing
      wr_bus.wr_ready = 1'b1;
      pulse_start();
      offer(16'h3c00, 16'h4000, 16'h0000, 2'b00, 4'b1000, 16'h4000, 4'h0, 4, a);
      chk("single_acc", 76'(a), 76'(1));
      chk("single_wr_en", 76'(wr_bus.wr_en), 76'(1));
      chk("single_addr", 76'(wr_bus.wr_addr), 76'(0));
      chk("single_data", wr_bus.wr_data, 76'h3c00_4000_0000_08_4000_0);
      tick(1);
      chk("single_count", 76'(rec_count), 76'(1));
      offer(16'h1234, 16'h5678, 16'h9abc, 2'b11, 4'b1110, 16'hdef0, 4'h9, 4, a);
      chk("ctrl_data", wr_bus.wr_data, 76'h1234_5678_9abc_3e_def0_9);
      tick(1);
      finish = 1'b1;
      tick(1);
      finish = 1'b0;
      wait_done(10);
      chk("run1_count", 76'(rec_count), 76'(2));

      // Finish/drain, with a capture landing on the finish cycle
      pulse_start();
      wr_bus.wr_ready = 1'b0;
      rnd_offer(4, a);
      finish = 1'b1;
      rnd_offer(4, a);
      finish = 1'b0;
      chk("finish_same_cycle_acc", 76'(a), 76'(1));
      wr_bus.wr_ready = 1'b1;
      wait_done(20);
      chk("drain_count", 76'(rec_count), 76'(2));
      rnd_offer(3, a);
      chk("post_done_refused", 76'(a), 76'(0));

      // Backpressure: FIFO fills at four, fifth waits; start mid-run is ignored
      pulse_start();
      wr_bus.wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rnd_offer(3, a);
         chk("bp_acc", 76'(a), 76'(1));
      end
      chk("bp_full_ready", 76'(cap_bus.cap_ready), 76'(0));
      rnd_offer(3, a);
      chk("bp_fifth_held", 76'(a), 76'(0));
      pulse_start();
      tick(2);
      wr_bus.wr_ready = 1'b1;
      rnd_offer(10, a);
      chk("bp_fifth_acc", 76'(a), 76'(1));
      tick(6);
      chk("bp_count", 76'(rec_count), 76'(5));
      finish = 1'b1;
      tick(1);
      finish = 1'b0;
      wait_done(10);

      // Memory full under random write backpressure
      pulse_start();
      rand_rdy = 1'b1;
      n_acc = 0;
      for (int i = 0; i < MEMD + 3; i++) begin
         rnd_offer(40, a);
         n_acc += int'(a);
      end
      chk("memfull_accepted", 76'(n_acc), 76'(MEMD));
      chk("memfull_dropped", 76'(dropped), 76'(1));
      chk("memfull_ready", 76'(cap_bus.cap_ready), 76'(0));
      rand_rdy = 1'b0;
      tick(1);
      wr_bus.wr_ready = 1'b1;
      finish = 1'b1;
      tick(1);
      finish = 1'b0;
      wait_done(40);
      chk("memfull_count", 76'(rec_count), 76'(MEMD));
      chk("memfull_dropped_held", 76'(dropped), 76'(1));

      // Reset mid-run discards queued records
      pulse_start();
      wr_bus.wr_ready = 1'b0;
      rnd_offer(4, a);
      rnd_offer(4, a);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("rst_wr_en", 76'(wr_bus.wr_en), 76'(0));
      chk("rst_count", 76'(rec_count), 76'(0));
      chk("rst_cap_ready", 76'(cap_bus.cap_ready), 76'(0));
      chk("rst_wr_data", wr_bus.wr_data, 76'h0);
      chk("rst_dropped", 76'(dropped), 76'(0));
      wr_bus.wr_ready = 1'b1;
      tick(5);
      chk("rst_no_write", 76'(rec_count), 76'(0));

      // Recorder still usable after a mid-run reset
      pulse_start();
      rnd_offer(4, a);
      tick(2);
      finish = 1'b1;
      tick(1);
      finish = 1'b0;
      wait_done(10);
      chk("post_reset_count", 76'(rec_count), 76'(1));

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
